// File: rtl/mxv_sequencer_pkg.sv
// Shared types and constants for the matrix-by-vector command sequencer.
// Holds the command opcodes, the FSM state encoding and the default sizes.
package mxv_sequencer_pkg;

    localparam int SEQ_MAX_N = 8;
    localparam int SEQ_DW    = 8;

    typedef logic [SEQ_DW-1:0] data_t;
    typedef logic [3:0]        nibble_t;

    typedef enum logic [1:0] {
        OP_SETN  = 2'd0,
        OP_LOADM = 2'd1,
        OP_LOADV = 2'd2,
        OP_RUN   = 2'd3
    } op_t;

    typedef enum logic [2:0] {
        IDLE,
        GET_N,
        LOAD_M,
        LOAD_V,
        RUN,
        WAIT_DONE,
        TX_REQ,
        TX_WAIT
    } seq_state_t;

endpackage

// File: rtl/mxv_sequencer_seq_counter.sv
// Loadable up-counter with a terminal-count compare.
// hit reports that the increment applied this cycle lands on term.
module seq_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         inc,
    input  logic [W-1:0] term,
    output logic [W-1:0] cnt,
    output logic         hit
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (inc) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
    assign hit = ((cnt_q + W'(1)) == term);

endmodule

// File: rtl/mxv_sequencer.sv
// Command-level sequencer: latches N, steers bytes into FIFO A/B, starts the
// processor array and drains the N results to the UART one row at a time.
module mxv_sequencer
    import mxv_sequencer_pkg::*;
#(
    parameter int MAX_N = SEQ_MAX_N,
    parameter int DW    = SEQ_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    input  logic [1:0]    cmd_op,
    input  logic          byte_valid,
    input  logic [DW-1:0] byte_in,
    input  logic          full_A,
    input  logic          proc_done,
    input  logic          tx_busy,
    output logic [3:0]    N,
    output logic          push_A,
    output logic          push_B,
    output logic [DW-1:0] fifo_data,
    output logic          clear,
    output logic          proc_start,
    output logic [3:0]    res_sel,
    output logic          transmit,
    output logic          busy,
    output logic          err
);

    localparam nibble_t MAX_N_NIB = nibble_t'(MAX_N);

    seq_state_t    state_q, state_d;
    nibble_t       n_q, n_d, res_sel_q, res_sel_d;
    logic [DW-1:0] fifo_data_q, fifo_data_d;
    logic          push_a_q, push_a_d, push_b_q, push_b_d;
    logic          clear_q, clear_d, proc_start_q, proc_start_d;
    logic          transmit_q, transmit_d, err_q, err_d;
    logic          m_loaded_q, m_loaded_d, v_loaded_q, v_loaded_d;
    logic          rose_q, rose_d, guard_q, guard_d;

    // elem_cnt is 8 bits wide so MAX_N up to 15 (225 elements) cannot wrap
    logic [7:0] elem_cnt_unused, elem_term, nn;
    logic       elem_load, elem_inc, elem_hit;
    nibble_t    row, cand;
    logic       row_load, row_inc, row_hit, tx_done;

    assign nn   = {4'b0, n_q} * {4'b0, n_q};
    assign cand = byte_in[3:0];

    seq_counter #(.W(8)) u_elem_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (elem_load),
        .load_val (8'd0),
        .inc      (elem_inc),
        .term     (elem_term),
        .cnt      (elem_cnt_unused),
        .hit      (elem_hit)
    );

    seq_counter #(.W(4)) u_row_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (row_load),
        .load_val (4'd0),
        .inc      (row_inc),
        .term     (n_q),
        .cnt      (row),
        .hit      (row_hit)
    );

    always_comb begin
        state_d      = state_q;
        n_d          = n_q;
        fifo_data_d  = fifo_data_q;
        res_sel_d    = res_sel_q;
        push_a_d     = 1'b0;
        push_b_d     = 1'b0;
        clear_d      = 1'b0;
        proc_start_d = 1'b0;
        transmit_d   = 1'b0;
        err_d        = err_q;
        m_loaded_d   = m_loaded_q;
        v_loaded_d   = v_loaded_q;
        rose_d       = rose_q;
        guard_d      = guard_q;
        elem_load    = 1'b0;
        elem_inc     = 1'b0;
        row_load     = 1'b0;
        row_inc      = 1'b0;
        tx_done      = 1'b0;
        elem_term    = (state_q == LOAD_M) ? nn : {4'b0, n_q};

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    case (op_t'(cmd_op))
                        OP_SETN:  state_d = GET_N;
                        OP_LOADM: begin
                            state_d   = LOAD_M;
                            elem_load = 1'b1;
                        end
                        OP_LOADV: begin
                            state_d   = LOAD_V;
                            elem_load = 1'b1;
                        end
                        default: begin
                            if (m_loaded_q && v_loaded_q) begin
                                proc_start_d = 1'b1;
                                state_d      = RUN;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                    endcase
                end
            end
            GET_N: begin
                if (byte_valid) begin
                    state_d = IDLE;
                    if (cand != 4'd0 && cand <= MAX_N_NIB) begin
                        n_d        = cand;
                        clear_d    = 1'b1;
                        m_loaded_d = 1'b0;
                        v_loaded_d = 1'b0;
                        err_d      = 1'b0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            LOAD_M, LOAD_V: begin
                if (byte_valid) begin
                    elem_inc    = 1'b1;
                    fifo_data_d = byte_in;
                    if (state_q == LOAD_V) begin
                        push_b_d = 1'b1;
                    end else if (full_A) begin
                        err_d = 1'b1;
                    end else begin
                        push_a_d = 1'b1;
                    end
                    if (elem_hit) begin
                        state_d = IDLE;
                        if (state_q == LOAD_M) m_loaded_d = 1'b1;
                        else                   v_loaded_d = 1'b1;
                    end
                end
            end
            RUN: state_d = WAIT_DONE;
            WAIT_DONE: begin
                if (proc_done) begin
                    row_load = 1'b1;
                    state_d  = TX_REQ;
                end
            end
            TX_REQ: begin
                if (!tx_busy) begin
                    res_sel_d  = row;
                    transmit_d = 1'b1;
                    rose_d     = 1'b0;
                    guard_d    = 1'b0;
                    state_d    = TX_WAIT;
                end
            end
            TX_WAIT: begin
                // A UART that never raises busy within two cycles is taken as done
                if (rose_q) begin
                    tx_done = !tx_busy;
                end else if (tx_busy) begin
                    rose_d = 1'b1;
                end else if (guard_q) begin
                    tx_done = 1'b1;
                end else begin
                    guard_d = 1'b1;
                end
                if (tx_done) begin
                    row_inc = 1'b1;
                    if (row_hit) begin
                        m_loaded_d = 1'b0;
                        v_loaded_d = 1'b0;
                        clear_d    = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        state_d = TX_REQ;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (cmd_valid && state_q != IDLE) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            n_q          <= 4'd1;
            fifo_data_q  <= '0;
            res_sel_q    <= '0;
            push_a_q     <= 1'b0;
            push_b_q     <= 1'b0;
            clear_q      <= 1'b0;
            proc_start_q <= 1'b0;
            transmit_q   <= 1'b0;
            err_q        <= 1'b0;
            m_loaded_q   <= 1'b0;
            v_loaded_q   <= 1'b0;
            rose_q       <= 1'b0;
            guard_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            n_q          <= n_d;
            fifo_data_q  <= fifo_data_d;
            res_sel_q    <= res_sel_d;
            push_a_q     <= push_a_d;
            push_b_q     <= push_b_d;
            clear_q      <= clear_d;
            proc_start_q <= proc_start_d;
            transmit_q   <= transmit_d;
            err_q        <= err_d;
            m_loaded_q   <= m_loaded_d;
            v_loaded_q   <= v_loaded_d;
            rose_q       <= rose_d;
            guard_q      <= guard_d;
        end
    end

    assign N          = n_q;
    assign push_A     = push_a_q;
    assign push_B     = push_b_q;
    assign fifo_data  = fifo_data_q;
    assign clear      = clear_q;
    assign proc_start = proc_start_q;
    assign res_sel    = res_sel_q;
    assign transmit   = transmit_q;
    assign err        = err_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_mxv_sequencer.sv
// Self-checking bench for mxv_sequencer: SETN vector table, hand-written
// corner sequences, and randomized load/run rounds against a queue model.
module tb_mxv_sequencer;
    import mxv_sequencer_pkg::*;

    localparam int MAXN = 8;

    logic       clk = 1'b0;
    logic       rst, cmd_valid, byte_valid, full_A, proc_done, tx_busy;
    logic [1:0] cmd_op;
    logic [7:0] byte_in, fifo_data;
    logic [3:0] N, res_sel;
    logic       push_A, push_B, clear, proc_start, transmit, busy, err;

    mxv_sequencer #(.MAX_N(MAXN), .DW(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_op     (cmd_op),
        .byte_valid (byte_valid),
        .byte_in    (byte_in),
        .full_A     (full_A),
        .proc_done  (proc_done),
        .tx_busy    (tx_busy),
        .N          (N),
        .push_A     (push_A),
        .push_B     (push_B),
        .fifo_data  (fifo_data),
        .clear      (clear),
        .proc_start (proc_start),
        .res_sel    (res_sel),
        .transmit   (transmit),
        .busy       (busy),
        .err        (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Observed strobes, logged mid-cycle
    logic [7:0] pa_q[$];
    logic [7:0] pb_q[$];
    int         tx_q[$];
    int         n_clear = 0;
    int         n_start = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (push_A)     pa_q.push_back(fifo_data);
            if (push_B)     pb_q.push_back(fifo_data);
            if (transmit)   tx_q.push_back(int'(res_sel));
            if (clear)      n_clear++;
            if (proc_start) n_start++;
        end
    end

    // Simple UART: optional rise delay, then busy for uart_len cycles
    bit uart_on  = 1'b1;
    int uart_dly = 0;
    int uart_len = 2;

    initial begin
        tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (transmit && uart_on) begin
                repeat (uart_dly) @(negedge clk);
                tx_busy = 1'b1;
                repeat (uart_len) @(negedge clk);
                tx_busy = 1'b0;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_cmd(input op_t op);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cyc();
        cmd_valid = 1'b0;
    endtask

    task automatic do_byte(input logic [7:0] b);
        byte_valid = 1'b1;
        byte_in    = b;
        cyc();
        byte_valid = 1'b0;
    endtask

    task automatic set_n(input logic [7:0] b);
        do_cmd(OP_SETN);
        do_byte(b);
    endtask

    task automatic wait_idle(input string name, input int maxc);
        int k = 0;
        while (busy && k < maxc) begin
            cyc();
            k++;
        end
        check(name, busy, 0);
    endtask

    task automatic pulse_done();
        proc_done = 1'b1;
        cyc();
        proc_done = 1'b0;
    endtask

    // Expected: N transmits with rows 0..n-1, one start, one final clear
    task automatic run_drain(input string tag, input int n, input logic exp_err);
        int s0 = tx_q.size();
        int c0 = n_clear;
        int p0 = n_start;
        do_cmd(OP_RUN);
        cyc($urandom_range(1, 4));
        pulse_done();
        wait_idle({tag, "_idle"}, 50 * n + 20);
        cyc();
        check({tag, "_ntx"}, tx_q.size() - s0, n);
        for (int i = 0; i < n; i++) begin
            if (s0 + i < tx_q.size()) check({tag, "_row"}, tx_q[s0 + i], i);
        end
        check({tag, "_clear"}, n_clear - c0, 1);
        check({tag, "_start"}, n_start - p0, 1);
        check({tag, "_err"}, err, exp_err);
    endtask

    typedef struct {
        logic [7:0] b;
        logic [3:0] exp_n;
        logic       exp_err;
        logic       exp_clr;
    } setn_vec_t;

    setn_vec_t  tv[7];
    int         n, a0, b0;
    logic [7:0] b;
    logic       exp_err;
    logic [7:0] exp_a[$];
    logic [7:0] exp_b[$];

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; byte_valid = 1'b0;
        byte_in = 8'd0; full_A = 1'b0; proc_done = 1'b0;
        cyc(2);
        check("rst_n", N, 1);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_strobes", {push_A, push_B, clear, proc_start, transmit}, 0);
        check("rst_data", {fifo_data, res_sel}, 0);
        rst = 1'b0;
        cyc();

        // SETN vectors: candidate is the low nibble, legal range 1..MAXN
        tv[0] = '{8'h03, 4'd3, 1'b0, 1'b1};
        tv[1] = '{8'h00, 4'd3, 1'b1, 1'b0};
        tv[2] = '{8'h09, 4'd3, 1'b1, 1'b0};
        tv[3] = '{8'h1F, 4'd3, 1'b1, 1'b0};
        tv[4] = '{8'h28, 4'd8, 1'b0, 1'b1};
        tv[5] = '{8'hF1, 4'd1, 1'b0, 1'b1};
        tv[6] = '{8'h02, 4'd2, 1'b0, 1'b1};
        for (int i = 0; i < 7; i++) begin
            do_cmd(OP_SETN);
            check("setn_busy", busy, 1);
            do_byte(tv[i].b);
            check("setn_n", N, tv[i].exp_n);
            check("setn_err", err, tv[i].exp_err);
            check("setn_clear", clear, tv[i].exp_clr);
            check("setn_idle", busy, 0);
            cyc();
            check("setn_clear_1cyc", clear, 0);
        end

        // N=2 matrix and vector load with per-byte timing
        do_cmd(OP_LOADM);
        for (int k = 1; k <= 4; k++) begin
            do_byte(8'(k));
            check("ldm_push", push_A, 1);
            check("ldm_data", fifo_data, k);
            check("ldm_nopushb", push_B, 0);
            check("ldm_busy", busy, (k < 4) ? 1 : 0);
            cyc();
            check("ldm_push_1cyc", push_A, 0);
        end
        do_cmd(OP_LOADV);
        for (int k = 5; k <= 6; k++) begin
            do_byte(8'(k));
            check("ldv_push", push_B, 1);
            check("ldv_data", fifo_data, k);
            check("ldv_nopusha", push_A, 0);
        end
        check("ldv_idle", busy, 0);

        // RUN and two-row drain with a well-behaved UART
        a0 = tx_q.size();
        b0 = n_clear;
        uart_on = 1'b1; uart_dly = 0; uart_len = 3;
        do_cmd(OP_RUN);
        check("run_start", proc_start, 1);
        check("run_busy", busy, 1);
        cyc();
        check("run_start_1cyc", proc_start, 0);
        cyc(2);
        pulse_done();
        wait_idle("run_idle", 60);
        cyc();
        check("run_ntx", tx_q.size() - a0, 2);
        if (tx_q.size() >= a0 + 2) begin
            check("run_row0", tx_q[a0], 0);
            check("run_row1", tx_q[a0 + 1], 1);
        end
        check("run_clear", n_clear - b0, 1);
        check("run_err", err, 0);

        // RUN with only the matrix loaded, then bad/good SETN
        do_cmd(OP_LOADM);
        for (int k = 0; k < 4; k++) do_byte(8'h40 + 8'(k));
        do_cmd(OP_RUN);
        check("run_nov_start", proc_start, 0);
        check("run_nov_err", err, 1);
        check("run_nov_idle", busy, 0);
        set_n(8'h00);
        check("setn0_n", N, 2);
        check("setn0_err", err, 1);
        set_n(8'h02);
        check("setn2_err", err, 0);

        // full_A on the second byte: byte dropped but still counted
        a0 = pa_q.size();
        do_cmd(OP_LOADM);
        do_byte(8'd10);
        full_A = 1'b1;
        do_byte(8'd11);
        full_A = 1'b0;
        check("full_nopush", push_A, 0);
        check("full_err", err, 1);
        do_byte(8'd12);
        check("full_push3", push_A, 1);
        check("full_busy3", busy, 1);
        do_byte(8'd13);
        check("full_end", busy, 0);
        cyc();
        check("full_npush", pa_q.size() - a0, 3);

        // Command during WAIT_DONE, then reset in TX_WAIT
        set_n(8'h02);
        do_cmd(OP_LOADM);
        for (int k = 0; k < 4; k++) do_byte(8'(k));
        do_cmd(OP_LOADV);
        for (int k = 0; k < 2; k++) do_byte(8'(k));
        do_cmd(OP_RUN);
        cyc();
        do_cmd(OP_SETN);
        check("wd_cmd_err", err, 1);
        check("wd_cmd_busy", busy, 1);
        check("wd_cmd_n", N, 2);
        uart_dly = 0; uart_len = 20;
        pulse_done();
        for (int k = 0; k < 10 && !transmit; k++) cyc();
        check("rsttx_seen", transmit, 1);
        cyc();
        rst = 1'b1;
        cyc();
        check("rsttx_idle", busy, 0);
        check("rsttx_transmit", transmit, 0);
        check("rsttx_n", N, 1);
        check("rsttx_err", err, 0);
        rst = 1'b0;
        cyc(25);

        // Randomized rounds against the queue model
        for (int it = 0; it < 16; it++) begin
            n = $urandom_range(1, MAXN);
            set_n({4'($urandom_range(0, 15)), 4'(n)});
            check("rnd_n", N, n);
            check("rnd_err0", err, 0);
            exp_err = 1'b0;
            exp_a.delete();
            exp_b.delete();
            a0 = pa_q.size();
            b0 = pb_q.size();
            do_cmd(OP_LOADM);
            for (int k = 0; k < n * n; k++) begin
                b = 8'($urandom);
                full_A = ($urandom_range(0, 7) == 0);
                if (full_A) exp_err = 1'b1;
                else        exp_a.push_back(b);
                do_byte(b);
                full_A = 1'b0;
                cyc($urandom_range(0, 2));
            end
            cyc();
            check("rnd_ldm_idle", busy, 0);
            check("rnd_ldm_cnt", pa_q.size() - a0, exp_a.size());
            for (int k = 0; k < exp_a.size(); k++) begin
                if (a0 + k < pa_q.size()) check("rnd_ldm_data", pa_q[a0 + k], exp_a[k]);
            end
            do_cmd(OP_LOADV);
            for (int k = 0; k < n; k++) begin
                b = 8'($urandom);
                exp_b.push_back(b);
                do_byte(b);
                cyc($urandom_range(0, 2));
            end
            cyc();
            check("rnd_ldv_idle", busy, 0);
            check("rnd_ldv_cnt", pb_q.size() - b0, exp_b.size());
            for (int k = 0; k < exp_b.size(); k++) begin
                if (b0 + k < pb_q.size()) check("rnd_ldv_data", pb_q[b0 + k], exp_b[k]);
            end
            uart_on  = ($urandom_range(0, 1) == 1);
            uart_dly = $urandom_range(0, 2);
            uart_len = $urandom_range(1, 4);
            run_drain("rnd_run", n, exp_err);
            cyc(8);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
